if_fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage ARM-subset pipeline, directly upstream of the decode stage. Holds the program counter and issues requests to the instruction memory over a req/ack handshake that tolerates wait states. Delivers each fetched instruction and its PC+4 through the IF/ID pipeline register. Honours the decode-stage hazard freeze and the execute-stage branch redirect, which also flushes the fetch.

---
 rtl/if_fetch_unit.sv | 159 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit : instruction-fetch stage with a req/ack imem port and an IF/ID register.
// Optional wait-state counter is built when IF_STALL_CNT_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic        valid_o,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;

  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign target   = {branch_addr_i[31:2], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  assign imem_req_o  = (state_q == REQ) || (state_q == DRAIN);
  assign imem_addr_o = (state_q == DRAIN) ? req_addr_q : pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    hold_d        = hold_q;
    deliver       = 1'b0;
    deliver_instr = 32'd0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (branch_taken_i) pc_d = target;
      end
      REQ: begin
        if (imem_ack_i) begin
          if (branch_taken_i) begin
            pc_d = target;
          end else if (freeze_i) begin
            hold_d  = imem_rdata_i;
            state_d = HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata_i;
            pc_d          = pc_plus4;
          end
        end else if (branch_taken_i) begin
          // The in-flight request must complete; remember its address for DRAIN.
          req_addr_d = pc_q;
          pc_d       = target;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (branch_taken_i) pc_d = target;
        if (imem_ack_i) state_d = REQ;
      end
      HOLD: begin
        if (branch_taken_i) begin
          pc_d    = target;
          state_d = REQ;
        end else if (!freeze_i) begin
          deliver       = 1'b1;
          deliver_instr = hold_q;
          pc_d          = pc_plus4;
          state_d       = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_pc_d    = 32'd0;
    if_instr_d = 32'd0;
    if_valid_d = 1'b0;
    if (!branch_taken_i && freeze_i) begin
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if_valid_d = if_valid_q;
    end else if (!branch_taken_i && deliver) begin
      if_pc_d    = pc_plus4;
      if_instr_d = deliver_instr;
      if_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= 32'd0;
      hold_q     <= 32'd0;
      if_pc_q    <= 32'd0;
      if_instr_q <= 32'd0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      hold_q     <= hold_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign pc_o          = if_pc_q;
  assign instruction_o = if_instr_q;
  assign valid_o       = if_valid_q;

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
    end else if (imem_req_o && !imem_ack_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit : directed bench for if_fetch_unit with a word=address memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;
  logic [31:0] stall_cycles;

  logic        ack_en;
  int          n_checks;
  int          n_err;
  int          exp_stall;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .freeze_i       (freeze),
    .branch_taken_i (branch_taken),
    .branch_addr_i  (branch_addr),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_ack_i     (imem_ack),
    .imem_rdata_i   (imem_rdata),
    .pc_o           (pc_out),
    .instruction_o  (instr_out),
    .valid_o        (valid_out),
    .stall_cycles_o (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns the word equal to its address; ack gated by the stimulus.
  always_comb begin
    imem_rdata = imem_addr;
    imem_ack   = ack_en & imem_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] p, input logic [31:0] i,
                          input logic v);
    chk({tag, ".PC"}, pc_out, p);
    chk({tag, ".Instr"}, instr_out, i);
    chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] stall_exp(input int n);
`ifdef IF_STALL_CNT_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    n_checks     = 0;
    n_err        = 0;
    exp_stall    = 0;
    rst_n        = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'd0;
    ack_en       = 1'b1;

    step;
    chk_ifid("reset", 32'd0, 32'd0, 1'b0);
    chk("reset.req", {31'd0, imem_req}, 32'd0);
    chk("reset.stall", stall_cycles, 32'd0);
    rst_n = 1'b1;

    // First edge after release: request issued, nothing delivered yet.
    step;
    chk("first.req", {31'd0, imem_req}, 32'd1);
    chk("first.addr", imem_addr, 32'h0);
    chk("first.valid", {31'd0, valid_out}, 32'd0);

    step;
    chk_ifid("seq0", 32'h4, 32'h0, 1'b1);
    chk("seq0.addr", imem_addr, 32'h4);
    step;
    chk_ifid("seq1", 32'h8, 32'h4, 1'b1);
    chk("seq1.addr", imem_addr, 32'h8);

    // Freeze for three cycles while the word at 0x8 returns.
    freeze = 1'b1;
    step;
    chk_ifid("frz1", 32'h8, 32'h4, 1'b1);
    chk("frz1.req", {31'd0, imem_req}, 32'd0);
    step;
    chk_ifid("frz2", 32'h8, 32'h4, 1'b1);
    step;
    chk_ifid("frz3", 32'h8, 32'h4, 1'b1);
    freeze = 1'b0;
    step;
    chk_ifid("unfrz", 32'hC, 32'h8, 1'b1);
    chk("unfrz.addr", imem_addr, 32'hC);
    step;
    chk_ifid("seq2", 32'h10, 32'hC, 1'b1);
    chk("seq2.addr", imem_addr, 32'h10);

    // Two wait states at 0x10 with a branch to 0x103 in the first.
    ack_en       = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'h103;
    step;
    exp_stall++;
    branch_taken = 1'b0;
    chk_ifid("brw1", 32'd0, 32'd0, 1'b0);
    chk("brw1.addr", imem_addr, 32'h10);
    chk("brw1.req", {31'd0, imem_req}, 32'd1);
    step;
    exp_stall++;
    chk("brw2.addr", imem_addr, 32'h10);
    chk("brw2.valid", {31'd0, valid_out}, 32'd0);
    ack_en = 1'b1;
    step;
    chk("drain.addr", imem_addr, 32'h100);
    chk_ifid("drain", 32'd0, 32'd0, 1'b0);
    chk("drain.stall", stall_cycles, stall_exp(exp_stall));
    step;
    chk_ifid("tgt", 32'h104, 32'h100, 1'b1);
    chk("tgt.addr", imem_addr, 32'h104);

    // Enter HOLD, then branch and freeze together.
    freeze = 1'b1;
    step;
    chk_ifid("hold", 32'h104, 32'h100, 1'b1);
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    step;
    branch_taken = 1'b0;
    freeze       = 1'b0;
    chk_ifid("holdbr", 32'd0, 32'd0, 1'b0);
    chk("holdbr.addr", imem_addr, 32'h200);
    chk("holdbr.req", {31'd0, imem_req}, 32'd1);
    step;
    chk_ifid("holdtgt", 32'h204, 32'h200, 1'b1);

    // Branch with ack in REQ to the last word, then wrap.
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    step;
    branch_taken = 1'b0;
    chk_ifid("brack", 32'd0, 32'd0, 1'b0);
    chk("brack.addr", imem_addr, 32'hFFFF_FFFC);
    step;
    chk_ifid("wrap", 32'h0, 32'hFFFF_FFFC, 1'b1);
    chk("wrap.addr", imem_addr, 32'h0);

    // Reset asserted in the middle of a DRAIN.
    ack_en       = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'h300;
    step;
    exp_stall++;
    branch_taken = 1'b0;
    step;
    exp_stall++;
    chk("mid.addr", imem_addr, 32'h0);
    chk("mid.stall", stall_cycles, stall_exp(exp_stall));
    #2;
    rst_n = 1'b0;
    #1;
    chk_ifid("arst", 32'd0, 32'd0, 1'b0);
    chk("arst.req", {31'd0, imem_req}, 32'd0);
    chk("arst.stall", stall_cycles, 32'd0);
    ack_en = 1'b1;
    step;
    rst_n = 1'b1;
    step;
    chk("rst2.addr", imem_addr, 32'h0);
    chk("rst2.req", {31'd0, imem_req}, 32'd1);
    step;
    chk_ifid("rst2", 32'h4, 32'h0, 1'b1);
    step;
    chk_ifid("rst2b", 32'h8, 32'h4, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
